ram_burst_master: RTL
=====================

Name: ram_burst_master

Overview:
Initiator that drives the single-port synchronous RAM interface: rd_wr, addr, data_in and data_out, with the 1-cycle registered read. It accepts burst commands over a valid/ready handshake and streams write data from a valid/ready source into consecutive RAM locations. For read bursts it issues one read per cycle and returns the RAM data as a valid-qualified stream. It sits between a host/sequencer and the RAM and is the only agent driving the RAM's rd_wr and addr.

Parameters:
DATA_W, 8, RAM word width
ADDR_W, 5, RAM address width (depth 2^ADDR_W = 32)

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  asynchronous, active-high reset
cmd_valid  in  1  command request
cmd_ready  out  1  command accepted when cmd_valid && cmd_ready at a rising edge
cmd_wr  in  1  1 = write burst, 0 = read burst
cmd_addr  in  ADDR_W  burst start address
cmd_len  in  ADDR_W  beats minus one (0 → 1 beat, 31 → 32 beats)
wdata  in  DATA_W  write data
wdata_valid  in  1  write data valid
wdata_ready  out  1  write beat accepted when wdata_valid && wdata_ready
rdata  out  DATA_W  read data
rdata_valid  out  1  rdata valid this cycle (no backpressure)
busy  out  1  burst in progress
done  out  1  one-cycle pulse at burst completion
mem_rd_wr  out  1  to RAM rd_wr (1 = write)
mem_addr  out  ADDR_W  to RAM addr
mem_data_in  out  DATA_W  to RAM data_in
mem_data_out  in  DATA_W  from RAM data_out

Behaviour:
- FSM states: IDLE, WRITE, READ, DRAIN. Registers: addr_reg (ADDR_W bits), cnt (ADDR_W bits), rd_pend, done_r.
- Reset values: state=IDLE, addr_reg=0, cnt=0, rd_pend=0, done_r=0.
- Outputs at reset: cmd_ready=1, wdata_ready=0, rdata_valid=0, busy=0, done=0, mem_rd_wr=0, mem_addr=0, mem_data_in=0.
- IDLE: cmd_ready=1, mem_rd_wr=0, mem_data_in=0. On command handshake: addr_reg←cmd_addr, cnt←cmd_len, next state WRITE if cmd_wr=1, else READ.
- busy=1 in WRITE, READ and DRAIN. cmd_ready=0 outside IDLE. Commands presented while busy wait; they are never dropped or queued.
- mem_addr=addr_reg at all times.
- WRITE:
  - wdata_ready=1.
  - mem_rd_wr=wdata_valid (combinational); mem_data_in=wdata.
  - On each beat handshake: addr_reg+1, cnt−1.
  - On the beat with cnt=0: next state IDLE and done_r←1.
  - A cycle with wdata_valid=0 performs no RAM write and holds addr_reg and cnt.
- READ:
  - mem_rd_wr=0; one read issued every cycle at addr_reg.
  - Each cycle: rd_pend←1, addr_reg+1, cnt−1.
  - When cnt=0: next state DRAIN.
- DRAIN: one cycle. Then IDLE.
- Read return:
  - rdata=mem_data_out (pass-through); rdata_valid=rd_pend.
  - A read issued in cycle N yields rdata_valid=1 in cycle N+1 with the data of that address.
  - rd_pend←0 in any cycle where no read is issued.
- Read timing: command accepted at edge E0; the first read is issued in the following cycle; the first rdata_valid comes in the cycle after E0+1 edge. Reads stream at 1 beat/cycle.
- done:
  - Write burst: done=done_r, high for the single cycle after the final write edge. This cycle is also IDLE, so a new command may be accepted in it.
  - Read burst: done=1 during DRAIN, coincident with the last rdata_valid.
- Address arithmetic is modulo 2^ADDR_W: 31+1 wraps to 0. A 32-beat burst touches every location exactly once.
- In DRAIN and IDLE, mem_rd_wr=0, so no spurious RAM writes occur.
- Reset mid-burst: asserting rst immediately (asynchronously) forces IDLE. busy, rdata_valid, done and mem_rd_wr go to 0 without waiting for a clock edge. Partial writes already done remain in RAM. The block accepts a command on the first edge after rst deasserts.

Test Plan:
1. Write cmd_addr=0, cmd_len=3, wdata 0x11,0x22,0x33,0x44 back-to-back → mem_rd_wr=1 for 4 cycles at mem_addr 0..3; done pulses 1 cycle after last beat. Then read cmd_addr=0, cmd_len=3 → rdata 0x11,0x22,0x33,0x44 on 4 consecutive rdata_valid cycles; done with the 0x44 beat.
2. Write 4 beats with wdata_valid low for 2 cycles between beats 2 and 3 → mem_rd_wr=0 and mem_addr held in gap cycles; readback matches with no extra writes.
3. Wrap: write cmd_addr=30, cmd_len=3, data A,B,C,D → writes at 30,31,0,1. Read cmd_addr=30, cmd_len=3 → A,B,C,D.
4. Full depth: write cmd_len=31 with data=addr^0x5A → read cmd_len=31 returns all 32 values in order. busy high exactly 32 (write) / 33 (read incl. DRAIN) cycles.
5. cmd_valid held high during a burst → cmd_ready=0, no state change. Command accepted in the first IDLE cycle (same cycle as write done) and executed correctly.
6. Assert rst during 3rd read beat → busy, rdata_valid, mem_rd_wr = 0 immediately. After deassert, a 1-beat read (cmd_len=0) of a written address returns the correct value with done.

Source files
------------

// File: rtl/ram_burst_master.sv
// Burst initiator for a single-port synchronous RAM with 1-cycle registered read.
// Accepts write/read burst commands, streams write beats in and read data out.
module ram_burst_master #(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 5
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic              cmd_wr,
   input  logic [ADDR_W-1:0] cmd_addr,
   input  logic [ADDR_W-1:0] cmd_len,
   input  logic [DATA_W-1:0] wdata,
   input  logic              wdata_valid,
   output logic              wdata_ready,
   output logic [DATA_W-1:0] rdata,
   output logic              rdata_valid,
   output logic              busy,
   output logic              done,
   output logic              mem_rd_wr,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_data_in,
   input  logic [DATA_W-1:0] mem_data_out
);

   typedef enum logic [1:0] {IDLE, WRITE, READ, DRAIN} state_t;

   state_t            state, state_nx;
   logic [ADDR_W-1:0] addr_reg, addr_nx;
   logic [ADDR_W-1:0] cnt, cnt_nx;
   logic              rd_pend, rd_pend_nx;
   logic              done_r, done_nx;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= IDLE;
         addr_reg <= '0;
         cnt      <= '0;
         rd_pend  <= 1'b0;
         done_r   <= 1'b0;
      end else begin
         state    <= state_nx;
         addr_reg <= addr_nx;
         cnt      <= cnt_nx;
         rd_pend  <= rd_pend_nx;
         done_r   <= done_nx;
      end
   end

   always_comb begin
      state_nx    = state;
      addr_nx     = addr_reg;
      cnt_nx      = cnt;
      rd_pend_nx  = 1'b0;
      done_nx     = 1'b0;
      cmd_ready   = 1'b0;
      wdata_ready = 1'b0;
      busy        = 1'b1;
      mem_rd_wr   = 1'b0;
      mem_data_in = '0;
      case (state)
         IDLE: begin
            cmd_ready = 1'b1;
            busy      = 1'b0;
            if (cmd_valid) begin
               addr_nx  = cmd_addr;
               cnt_nx   = cmd_len;
               state_nx = cmd_wr ? WRITE : READ;
            end
         end
         WRITE: begin
            // A stalled source simply holds address and count; no RAM write is issued.
            wdata_ready = 1'b1;
            mem_rd_wr   = wdata_valid;
            mem_data_in = wdata;
            if (wdata_valid) begin
               addr_nx = addr_reg + ADDR_W'(1);
               cnt_nx  = cnt - ADDR_W'(1);
               if (cnt == '0) begin
                  state_nx = IDLE;
                  done_nx  = 1'b1;
               end
            end
         end
         READ: begin
            rd_pend_nx = 1'b1;
            addr_nx    = addr_reg + ADDR_W'(1);
            cnt_nx     = cnt - ADDR_W'(1);
            if (cnt == '0)
               state_nx = DRAIN;
         end
         DRAIN: begin
            state_nx = IDLE;
         end
         default: begin
            state_nx = IDLE;
         end
      endcase
   end

   // Read data returns one cycle after issue, so the last beat lands in DRAIN.
   assign done        = done_r | (state == DRAIN);
   assign mem_addr    = addr_reg;
   assign rdata       = mem_data_out;
   assign rdata_valid = rd_pend;

endmodule
